// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen APB bridge: register-side status encoding,
// bridge FSM states and a small status decode helper.
package rggen_rtl_pkg;

    // Register-side completion status returned by the bit-field logic.
    typedef enum logic [1:0] {
        OKAY         = 2'd0,
        EXOKAY       = 2'd1,
        SLAVE_ERROR  = 2'd2,
        DECODE_ERROR = 2'd3
    } rggen_status;

    // Bridge FSM: one register access per APB transfer.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESPONSE = 2'd2
    } rggen_apb_bridge_state_e;

    // Both error encodings map onto the single APB error flag.
    function automatic logic is_error_status(rggen_status status);
        return (status == SLAVE_ERROR) || (status == DECODE_ERROR);
    endfunction

endpackage

// File: rtl/rggen_apb_bridge_if.sv
// Bus bundle for rggen_apb_bridge: APB slave port plus the register-side
// request/response port. The slave modport is the bridge view; the master
// modport is the environment view (APB requester and register responder).
//
// Handshake: the bridge raises o_reg_valid with the request held stable;
// the request completes in the cycle i_reg_ready is 1, and i_reg_read_data
// and i_reg_status are only sampled in that cycle. On the APB side a
// transfer completes in the single cycle o_pready is 1.
interface rggen_apb_bridge_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                       i_psel;
    logic                       i_penable;
    logic [ADDRESS_WIDTH-1:0]   i_paddr;
    logic                       i_pwrite;
    logic [BUS_WIDTH-1:0]       i_pwdata;
    logic [BUS_WIDTH/8-1:0]     i_pstrb;
    logic                       o_pready;
    logic [BUS_WIDTH-1:0]       o_prdata;
    logic                       o_pslverr;

    logic                       o_reg_valid;
    logic                       o_reg_write;
    logic [ADDRESS_WIDTH-1:0]   o_reg_address;
    logic [BUS_WIDTH-1:0]       o_reg_write_data;
    logic [BUS_WIDTH-1:0]       o_reg_write_mask;
    logic                       i_reg_ready;
    logic [BUS_WIDTH-1:0]       i_reg_read_data;
    logic [1:0]                 i_reg_status;

    modport master (
        output i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pstrb,
        input  o_pready, o_prdata, o_pslverr,
        input  o_reg_valid, o_reg_write, o_reg_address, o_reg_write_data, o_reg_write_mask,
        output i_reg_ready, i_reg_read_data, i_reg_status
    );

    modport slave (
        input  i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pstrb,
        output o_pready, o_prdata, o_pslverr,
        output o_reg_valid, o_reg_write, o_reg_address, o_reg_write_data, o_reg_write_mask,
        input  i_reg_ready, i_reg_read_data, i_reg_status
    );
endinterface

// File: rtl/rggen_apb_bridge_watchdog.sv
// Counts consecutive ACCESS cycles and flags the cycle in which the access
// has lasted TIMEOUT_CYCLES cycles. Used only in builds with
// RGGEN_APB_BRIDGE_TIMEOUT_EN defined.
module rggen_apb_bridge_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    output logic o_timeout
);
    logic [15:0] count;

    // Count cycles spent in ACCESS; restart whenever the access ends.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_active) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    assign o_timeout = i_active && (count == 16'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/rggen_apb_bridge.sv
// APB-to-rggen register bridge. Converts one APB transfer into one
// register-side access (IDLE -> ACCESS -> RESPONSE -> IDLE), giving one
// APB wait state minimum. Optional access timeout is enabled by defining
// RGGEN_APB_BRIDGE_TIMEOUT_EN; otherwise ACCESS waits indefinitely.
module rggen_apb_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    rggen_apb_bridge_if.slave       bus,
    output rggen_apb_bridge_state_e o_state
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    rggen_apb_bridge_state_e    state;
    rggen_apb_bridge_state_e    next_state;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic                       write_q;
    logic [BUS_WIDTH-1:0]       wdata_q;
    logic [STRB_WIDTH-1:0]      strb_q;
    logic [BUS_WIDTH-1:0]       rdata_q;
    rggen_status                status_q;
    logic [BUS_WIDTH-1:0]       mask;
    logic                       setup;
    logic                       timeout;

    assign setup   = bus.i_psel && !bus.i_penable;
    assign o_state = state;

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    rggen_apb_bridge_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_active  (state == ACCESS),
        .o_timeout (timeout)
    );
`else
    // No watchdog in this build: the comparison is constant false and only
    // keeps TIMEOUT_CYCLES referenced.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; psel dropping mid-access does not abort the access.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (setup) next_state = ACCESS;
            ACCESS:   if (bus.i_reg_ready || timeout) next_state = RESPONSE;
            RESPONSE: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Capture the APB request at the setup phase, only while idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if ((state == IDLE) && setup) begin
            addr_q  <= bus.i_paddr & ~ADDRESS_WIDTH'(STRB_WIDTH - 1);
            write_q <= bus.i_pwrite;
            wdata_q <= bus.i_pwdata;
            strb_q  <= bus.i_pstrb;
        end
    end

    // Capture the register response; ready wins over a same-cycle timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q  <= '0;
            status_q <= OKAY;
        end else if (state == ACCESS) begin
            if (bus.i_reg_ready) begin
                rdata_q  <= write_q ? '0 : bus.i_reg_read_data;
                status_q <= rggen_status'(bus.i_reg_status);
            end else if (timeout) begin
                rdata_q  <= '0;
                status_q <= SLAVE_ERROR;
            end
        end
    end

    // Expand byte strobes to a per-bit write mask; reads carry no mask.
    always_comb begin
        mask = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            mask[8*i +: 8] = {8{strb_q[i] & write_q}};
        end
    end

    // Drive outputs only in their owning state, zero elsewhere.
    always_comb begin
        bus.o_reg_valid      = 1'b0;
        bus.o_reg_write      = 1'b0;
        bus.o_reg_address    = '0;
        bus.o_reg_write_data = '0;
        bus.o_reg_write_mask = '0;
        bus.o_pready         = 1'b0;
        bus.o_prdata         = '0;
        bus.o_pslverr        = 1'b0;
        if (state == ACCESS) begin
            bus.o_reg_valid      = 1'b1;
            bus.o_reg_write      = write_q;
            bus.o_reg_address    = addr_q;
            bus.o_reg_write_data = wdata_q;
            bus.o_reg_write_mask = mask;
        end else if (state == RESPONSE) begin
            bus.o_pready  = 1'b1;
            bus.o_prdata  = rdata_q;
            bus.o_pslverr = is_error_status(status_q);
        end
    end
endmodule
